// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and registered ALU operand outputs of the ALU input loader.
// o_op_err exists only when ALU_LOADER_OP_CHECK_EN is defined.
interface alu_input_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_valid;
  logic               o_update;
`ifdef ALU_LOADER_OP_CHECK_EN
  logic               o_op_err;
`endif

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op,
    input  o_data_a, o_data_b, o_op, o_valid, o_update
`ifdef ALU_LOADER_OP_CHECK_EN
    , input o_op_err
`endif
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op,
    output o_data_a, o_data_b, o_op, o_valid, o_update
`ifdef ALU_LOADER_OP_CHECK_EN
    , output o_op_err
`endif
  );
endinterface

// File: rtl/alu_input_loader.sv
// Captures A/B/OP from the switch bus on debounced button presses and holds them for the ALU.
// Latency: press to output <= 2 sync + DEBOUNCE_CYCLES + 2 cycles; no backpressure, loads are unconditional.
// ALU_LOADER_OP_CHECK_EN: reject OP loads outside the supported opcode set and pulse o_op_err.
module alu_input_loader #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  alu_input_loader_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_OP-1:0]   OP_RESET = NB_OP'(6'b100000);

  // Button index: 0 = A, 1 = B, 2 = OP.
  logic [NB_DATA-1:0] sw_s1_q, sw_s2_q;
  logic [2:0]         btn_s1_q, btn_s2_q;
  logic [2:0]         stable_q, stable_d;
  logic [2:0]         stable_dly_q;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_d [3];
  logic [2:0]         btn_raw;
  logic [2:0]         rise;

  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               loaded_a_q, loaded_a_d;
  logic               loaded_b_q, loaded_b_d;
  logic               loaded_op_q, loaded_op_d;
  logic               valid_q, valid_d;
  logic               update_q, update_d;
  logic               ld_a, ld_b, ld_op;
  logic [NB_OP-1:0]   op_cand;

`ifdef ALU_LOADER_OP_CHECK_EN
  logic               op_ok;
  logic               op_err_q, op_err_d;
`endif

  always_comb begin
    btn_raw = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (btn_s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = btn_s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    rise    = stable_q & ~stable_dly_q;
    op_cand = sw_s2_q[NB_OP-1:0];
    ld_a    = rise[0];
    ld_b    = rise[1];
`ifdef ALU_LOADER_OP_CHECK_EN
    op_ok   = op_cand inside {NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
                              NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
                              NB_OP'(6'b000010), NB_OP'(6'b100111)};
    ld_op    = rise[2] & op_ok;
    op_err_d = rise[2] & ~op_ok;
`else
    ld_op   = rise[2];
`endif

    data_a_d    = ld_a  ? sw_s2_q : data_a_q;
    data_b_d    = ld_b  ? sw_s2_q : data_b_q;
    op_d        = ld_op ? op_cand : op_q;
    loaded_a_d  = loaded_a_q  | ld_a;
    loaded_b_d  = loaded_b_q  | ld_b;
    loaded_op_d = loaded_op_q | ld_op;
    // Valid tracks the flags being written this edge so it rises with the final operand.
    valid_d     = valid_q | (loaded_a_d & loaded_b_d & loaded_op_d);
    update_d    = ld_a | ld_b | ld_op;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      op_q         <= OP_RESET;
      loaded_a_q   <= 1'b0;
      loaded_b_q   <= 1'b0;
      loaded_op_q  <= 1'b0;
      valid_q      <= 1'b0;
      update_q     <= 1'b0;
`ifdef ALU_LOADER_OP_CHECK_EN
      op_err_q     <= 1'b0;
`endif
    end else begin
      sw_s1_q      <= bus.i_sw;
      sw_s2_q      <= sw_s1_q;
      btn_s1_q     <= btn_raw;
      btn_s2_q     <= btn_s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      op_q         <= op_d;
      loaded_a_q   <= loaded_a_d;
      loaded_b_q   <= loaded_b_d;
      loaded_op_q  <= loaded_op_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
`ifdef ALU_LOADER_OP_CHECK_EN
      op_err_q     <= op_err_d;
`endif
    end
  end

  assign bus.o_data_a = data_a_q;
  assign bus.o_data_b = data_b_q;
  assign bus.o_op     = op_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_update = update_q;
`ifdef ALU_LOADER_OP_CHECK_EN
  assign bus.o_op_err = op_err_q;
`endif

endmodule
